// File: rtl/uart_cmd_link.sv
// Command/response front end between the UART byte transceiver and the config FSM.
// Assembles 3-byte commands with an inter-byte timeout and feeds the transmitter through a one-deep buffer.
`timescale 1ns/1ps
module uart_cmd_link #(
    parameter int unsigned TIMEOUT = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp_data,
    output logic        resp_sent,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        frame_err,
    output logic        tx_ovf
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {RX_B1, RX_B2, RX_B3, RX_HOLD} rx_state_e;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_e;

    rx_state_e          rx_state_q, rx_state_d;
    tx_state_e          tx_state_q, tx_state_d;
    logic [23:0]        cmd_q, cmd_d;
    logic               cmd_rdy_q, cmd_rdy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               frame_err_q, frame_err_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               trmt_q, trmt_d;
    logic               resp_sent_q, resp_sent_d;
    logic               tx_ovf_q, tx_ovf_d;
    logic               pend_vld_q, pend_vld_d;
    logic [7:0]         pend_data_q, pend_data_d;

    logic rx_take;
    logic tmo_hit;

    // A byte is taken in any slot state; HOLD back-pressures the receiver.
    assign rx_take = rx_rdy && (rx_state_q != RX_HOLD);
    assign tmo_hit = ((rx_state_q == RX_B2) || (rx_state_q == RX_B3)) && !rx_rdy
                     && (cnt_q == CNT_W'(TIMEOUT - 1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q  <= RX_B1;
            tx_state_q  <= TX_IDLE;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
            tx_data_q   <= '0;
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
            tx_ovf_q    <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_data_q <= '0;
        end else begin
            rx_state_q  <= rx_state_d;
            tx_state_q  <= tx_state_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
            tx_data_q   <= tx_data_d;
            trmt_q      <= trmt_d;
            resp_sent_q <= resp_sent_d;
            tx_ovf_q    <= tx_ovf_d;
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
        end
    end

    // Receive next state
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_B1:   if (rx_rdy) rx_state_d = RX_B2;
            RX_B2:   if (rx_rdy) rx_state_d = RX_B3; else if (tmo_hit) rx_state_d = RX_B1;
            RX_B3:   if (rx_rdy) rx_state_d = RX_HOLD; else if (tmo_hit) rx_state_d = RX_B1;
            RX_HOLD: if (clr_cmd_rdy) rx_state_d = RX_B1;
            default: rx_state_d = RX_B1;
        endcase
    end

    // Receive outputs, byte slots and timeout counter
    always_comb begin
        clr_rx_rdy  = rst_n && rx_take;
        cmd_d       = cmd_q;
        cnt_d       = cnt_q + CNT_W'(1);
        cmd_rdy_d   = (rx_state_d == RX_HOLD);
        frame_err_d = tmo_hit;
        if (rx_take) begin
            case (rx_state_q)
                RX_B1:   cmd_d[23:16] = rx_data;
                RX_B2:   cmd_d[15:8]  = rx_data;
                default: cmd_d[7:0]   = rx_data;
            endcase
        end
        if (rx_take || tmo_hit || (rx_state_q == RX_B1) || (rx_state_q == RX_HOLD)) begin
            cnt_d = '0;
        end
    end

    // Transmit next state
    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE: if (send_resp) tx_state_d = TX_BUSY;
            TX_BUSY: if (tx_done && !pend_vld_q && !send_resp) tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Transmit outputs and pending buffer
    always_comb begin
        tx_data_d   = tx_data_q;
        trmt_d      = 1'b0;
        resp_sent_d = 1'b0;
        tx_ovf_d    = 1'b0;
        pend_vld_d  = pend_vld_q;
        pend_data_d = pend_data_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_data_d = resp_data;
                    trmt_d    = 1'b1;
                end
            end
            default: begin
                if (tx_done) begin
                    resp_sent_d = 1'b1;
                    if (pend_vld_q) begin
                        tx_data_d  = pend_data_q;
                        trmt_d     = 1'b1;
                        pend_vld_d = 1'b0;
                        tx_ovf_d   = send_resp;
                    end else if (send_resp) begin
                        // Simultaneous request goes straight to the transmitter.
                        tx_data_d = resp_data;
                        trmt_d    = 1'b1;
                    end
                end else if (send_resp) begin
                    if (pend_vld_q) begin
                        tx_ovf_d = 1'b1;
                    end else begin
                        pend_vld_d  = 1'b1;
                        pend_data_d = resp_data;
                    end
                end
            end
        endcase
    end

    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign frame_err = frame_err_q;
    assign tx_data   = tx_data_q;
    assign trmt      = trmt_q;
    assign resp_sent = resp_sent_q;
    assign tx_ovf    = tx_ovf_q;

endmodule

// File: tb/tb_uart_cmd_link.sv
// Directed bench for uart_cmd_link: command assembly, timeout, back-pressure, reset and response path.
`timescale 1ns/1ps
module tb_uart_cmd_link;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp_data;
    logic        resp_sent;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        frame_err;
    logic        tx_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    uart_cmd_link #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp_data(resp_data),
        .resp_sent(resp_sent), .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
        .frame_err(frame_err), .tx_ovf(tx_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Receiver model: byte held until the capture edge, then gap idle cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_rdy  = 1'b1;
        rx_data = b;
        #1;
        chk("clr_rx_rdy_on_byte", 32'(clr_rx_rdy), 32'h1);
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic pulse_clr_cmd();
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rx_rdy = 1'b0; rx_data = '0; clr_cmd_rdy = 1'b0;
        send_resp = 1'b0; resp_data = '0; tx_done = 1'b0;
        tick(); tick();
        chk("rst_cmd", 32'(cmd), 32'h0);
        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
        chk("rst_clr_rx_rdy", 32'(clr_rx_rdy), 32'h0);
        chk("rst_trmt", 32'(trmt), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_pulses", {29'd0, resp_sent, frame_err, tx_ovf}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic three-byte command and handshake
        send_byte(8'h02, 9);
        send_byte(8'h0D, 9);
        send_byte(8'h55, 2);
        chk("cmd_basic", 32'(cmd), 32'h020D55);
        chk("cmd_rdy_set", 32'(cmd_rdy), 32'h1);
        pulse_clr_cmd();
        chk("cmd_rdy_clr", 32'(cmd_rdy), 32'h0);
        chk("cmd_kept", 32'(cmd), 32'h020D55);

        // Timeout after byte 1 drops the frame, one-cycle frame_err
        send_byte(8'h01, 15);
        chk("no_err_early", 32'(frame_err), 32'h0);
        tick();
        chk("frame_err_pulse", 32'(frame_err), 32'h1);
        chk("no_cmd_rdy_tmo", 32'(cmd_rdy), 32'h0);
        tick();
        chk("frame_err_once", 32'(frame_err), 32'h0);
        send_byte(8'h07, 3);
        send_byte(8'h00, 3);
        send_byte(8'h00, 2);
        chk("cmd_after_tmo", 32'(cmd), 32'h070000);
        chk("cmd_rdy_after_tmo", 32'(cmd_rdy), 32'h1);

        // Back-pressure in HOLD, pending byte becomes next byte 1
        rx_rdy = 1'b1; rx_data = 8'hAA;
        #1;
        chk("hold_no_clr", 32'(clr_rx_rdy), 32'h0);
        tick(); tick(); tick();
        chk("hold_no_clr_late", 32'(clr_rx_rdy), 32'h0);
        chk("hold_cmd_stable", 32'(cmd), 32'h070000);
        pulse_clr_cmd();
        chk("hold_release_clr", 32'(clr_rx_rdy), 32'h1);
        tick();
        rx_rdy = 1'b0;
        chk("aa_byte1", 32'(cmd), 32'hAA0000);
        send_byte(8'h0B, 2);
        send_byte(8'h0C, 2);
        chk("cmd_aa", 32'(cmd), 32'hAA0B0C);
        pulse_clr_cmd();

        // Byte arriving on the expiry cycle wins
        send_byte(8'h31, 15);
        send_byte(8'h32, 0);
        chk("expiry_byte_wins", 32'(frame_err), 32'h0);
        tick();
        chk("expiry_byte_wins2", 32'(frame_err), 32'h0);
        send_byte(8'h33, 2);
        chk("cmd_expiry", 32'(cmd), 32'h313233);
        pulse_clr_cmd();

        // Reset mid-frame discards partial bytes
        send_byte(8'h09, 3);
        send_byte(8'h08, 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_cmd", 32'(cmd), 32'h0);
        chk("mid_rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
        send_byte(8'h05, 3);
        send_byte(8'h00, 3);
        send_byte(8'h03, 2);
        chk("cmd_after_rst", 32'(cmd), 32'h050003);
        chk("cmd_rdy_after_rst", 32'(cmd_rdy), 32'h1);
        pulse_clr_cmd();

        // Single response
        send_resp = 1'b1; resp_data = 8'hA5;
        tick();
        send_resp = 1'b0;
        chk("trmt_a5", 32'(trmt), 32'h1);
        chk("tx_data_a5", 32'(tx_data), 32'hA5);
        tick();
        chk("trmt_once", 32'(trmt), 32'h0);
        repeat (18) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("resp_sent_a5", 32'(resp_sent), 32'h1);
        chk("no_trmt_after", 32'(trmt), 32'h0);
        tick();
        chk("resp_sent_once", 32'(resp_sent), 32'h0);

        // Pending buffer and overflow
        send_resp = 1'b1; resp_data = 8'h11;
        tick();
        chk("trmt_11", 32'(trmt), 32'h1);
        chk("tx_data_11", 32'(tx_data), 32'h11);
        resp_data = 8'h22;
        tick();
        chk("no_trmt_22", 32'(trmt), 32'h0);
        chk("no_ovf_22", 32'(tx_ovf), 32'h0);
        resp_data = 8'h33;
        tick();
        send_resp = 1'b0;
        chk("ovf_33", 32'(tx_ovf), 32'h1);
        chk("tx_data_hold_11", 32'(tx_data), 32'h11);
        tick();
        chk("ovf_once", 32'(tx_ovf), 32'h0);
        repeat (4) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("b2b_resp_sent", 32'(resp_sent), 32'h1);
        chk("b2b_trmt", 32'(trmt), 32'h1);
        chk("b2b_tx_data", 32'(tx_data), 32'h22);
        repeat (3) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("last_resp_sent", 32'(resp_sent), 32'h1);
        chk("last_no_trmt", 32'(trmt), 32'h0);

        // send_resp coinciding with tx_done and an empty buffer
        tick();
        send_resp = 1'b1; resp_data = 8'h44;
        tick();
        send_resp = 1'b0;
        repeat (3) tick();
        send_resp = 1'b1; resp_data = 8'h55; tx_done = 1'b1;
        tick();
        send_resp = 1'b0; tx_done = 1'b0;
        chk("same_cyc_resp_sent", 32'(resp_sent), 32'h1);
        chk("same_cyc_trmt", 32'(trmt), 32'h1);
        chk("same_cyc_tx_data", 32'(tx_data), 32'h55);
        chk("same_cyc_no_ovf", 32'(tx_ovf), 32'h0);
        repeat (3) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("same_cyc_done", 32'(resp_sent), 32'h1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_link.md
# uart_cmd_link

Command/response front end between the UART byte transceiver and the command-config FSM. It assembles three received UART bytes, MSB first, into a 24-bit command. It presents that command with a `cmd_rdy`/`clr_cmd_rdy` handshake and applies an inter-byte timeout to discard partial frames. In the return direction it accepts `send_resp`/`resp_data` from the config FSM, drives the UART transmitter through a one-deep pending buffer, and reports completion with `resp_sent`.

## Interface
Parameters:
- `TIMEOUT`, 500000: idle cycles allowed between bytes 1→2 and 2→3 before the partial frame is dropped. Must be ≥ 2.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `rx_rdy` in 1: UART receiver byte valid. Level, held until `clr_rx_rdy`.
- `rx_data` in 8: received byte.
- `clr_rx_rdy` out 1: consumes the current byte.
- `cmd` out 24: assembled command; byte1 = `[23:16]`, byte2 = `[15:8]`, byte3 = `[7:0]`.
- `cmd_rdy` out 1: complete command available.
- `clr_cmd_rdy` in 1: consumer done with `cmd`.
- `send_resp` in 1: one-cycle request to transmit `resp_data`.
- `resp_data` in 8: response byte, sampled when `send_resp` is high.
- `resp_sent` out 1: one-cycle pulse per byte fully transmitted.
- `trmt` out 1: one-cycle start pulse to the UART transmitter.
- `tx_data` out 8: byte to transmit.
- `tx_done` in 1: transmitter finished the current byte (pulse).
- `frame_err` out 1: one-cycle pulse when a partial frame is dropped by timeout.
- `tx_ovf` out 1: one-cycle pulse when a response is dropped because the buffer is full.

## Operation
Receive FSM, states B1, B2, B3, HOLD; reset state B1:
- In Bn with `rx_rdy` high:
  - `clr_rx_rdy` is asserted combinationally in the same cycle, gated low while `rst_n` is low.
  - `rx_data` is written into byte slot n.
  - The FSM advances: B1→B2, B2→B3, B3→HOLD.
- HOLD: `cmd_rdy` is high. `clr_rx_rdy` is never asserted, so incoming bytes stay pending in the receiver (back-pressure).
- HOLD with `clr_cmd_rdy` → B1. `clr_cmd_rdy` in any other state is ignored.
- `cmd` changes only on byte capture. It is stable from HOLD entry until the next byte-1 capture, so it stays valid after `clr_cmd_rdy` until the next frame begins.
- Timeout counter:
  - Cleared on every byte capture and in B1/HOLD.
  - Counts in B2/B3.
  - Reaching `TIMEOUT-1` with no byte that cycle → B1, `frame_err` pulses, captured slots are left as-is (no `cmd_rdy`).
  - Byte arrival in the same cycle as expiry: the byte wins and no error is flagged.

Transmit FSM, states IDLE and BUSY, plus a pending register `pend_vld`/`pend_data`:
- IDLE with `send_resp`: latch `resp_data` into `tx_data`, pulse `trmt`, enter BUSY.
- BUSY with `send_resp` and `pend_vld`=0: store into the pending register.
- BUSY with `send_resp` and `pend_vld`=1: drop the byte and pulse `tx_ovf`.
- BUSY with `tx_done`: pulse `resp_sent`.
  - If `pend_vld`: load `pend_data` into `tx_data`, pulse `trmt`, clear `pend_vld`, stay BUSY.
  - Otherwise go to IDLE.
- `send_resp` and `tx_done` in the same cycle while BUSY with `pend_vld`=0: the new byte becomes the next transmission directly (`trmt` next cycle), with no drop.
- `tx_data` holds its value from `trmt` until the next load.

## Timing
- Reset values: `cmd`=0, `cmd_rdy`=0, `clr_rx_rdy`=0, `trmt`=0, `tx_data`=0, `resp_sent`=0, `frame_err`=0, `tx_ovf`=0, `pend_vld`=0, both FSMs in their reset state.
- Reset mid-frame or mid-transmit discards partial bytes and the pending byte.
- `clr_rx_rdy` is Mealy, 0 cycles after `rx_rdy`. The receiver drops `rx_rdy` at the next edge, so no byte is double-captured.
- `cmd_rdy` rises 1 cycle after the third byte's capture edge. It falls 1 cycle after `clr_cmd_rdy` is sampled.
- All pulses are registered, high for exactly 1 cycle, and asserted the cycle after the cause:
  - `trmt` after `send_resp` or `tx_done`;
  - `resp_sent` after `tx_done`;
  - `frame_err` after expiry;
  - `tx_ovf` after the rejected `send_resp`.
- Back-to-back responses: `resp_sent` of byte A and `trmt` of byte B are asserted in the same cycle.

## Test plan
- Send bytes 0x02, 0x0D, 0x55, one every 10 cycles → `cmd`=0x020D55, `cmd_rdy`=1. Pulse `clr_cmd_rdy` → `cmd_rdy`=0 the next cycle, `cmd` still 0x020D55.
- Send byte 0x01, then wait `TIMEOUT` cycles (use `TIMEOUT`=16) → `frame_err` pulses once. Then send 0x07, 0x00, 0x00 → `cmd`=0x070000.
- While in HOLD, assert `rx_rdy` with 0xAA → `clr_rx_rdy` stays 0 and `cmd` is unchanged. After `clr_cmd_rdy`, 0xAA is captured as byte 1.
- `send_resp` with 0xA5 → `trmt` the next cycle with `tx_data`=0xA5. `tx_done` after 20 cycles → `resp_sent` the next cycle.
- Send 0x11, 0x22, 0x33 on consecutive cycles while IDLE:
  - 0x11 transmits, 0x22 is pending, 0x33 is dropped with `tx_ovf`.
  - On `tx_done`: `resp_sent` and `trmt` are asserted together, with `tx_data`=0x22.
- Drop `rst_n` for 1 cycle after the second byte → the next three bytes 0x05, 0x00, 0x03 yield `cmd`=0x050003.
